// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and default sizing, also used by the RAT.
package rob_pkg;

  localparam int ROB_ENTRY_NUM   = 16;
  localparam int ROB_ENTRY_WIDTH = 4;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        mispredict;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] target;
  } rob_entry_t;

  // Fresh entry as written at allocation: valid, not yet executed.
  function automatic rob_entry_t new_entry(logic [4:0] rd, logic rd_we, logic [31:0] pc);
    rob_entry_t e;
    e            = '0;
    e.valid      = 1'b1;
    e.rd         = rd;
    e.rd_we      = rd_we;
    e.pc         = pc;
    return e;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Decode/writeback/query/commit bus between the ROB and its neighbours.
interface reorder_buffer_if #(
  parameter int ROB_ENTRY_WIDTH = rob_pkg::ROB_ENTRY_WIDTH
);
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [4:0]                 alloc_rd;
  logic                       alloc_rd_we;
  logic [31:0]                alloc_pc;
  logic [ROB_ENTRY_WIDTH-1:0] alloc_index;

  logic                       wb_valid;
  logic [ROB_ENTRY_WIDTH-1:0] wb_index;
  logic [31:0]                wb_data;
  logic                       wb_mispredict;
  logic [31:0]                wb_target;

  logic [ROB_ENTRY_WIDTH-1:0] query1_index;
  logic [ROB_ENTRY_WIDTH-1:0] query2_index;
  logic                       query1_ready;
  logic                       query2_ready;
  logic [31:0]                query1_data;
  logic [31:0]                query2_data;

  logic                       ROB_we;
  logic [4:0]                 ROB_addr_commit;
  logic [31:0]                ROB_data_commit;
  logic [ROB_ENTRY_WIDTH-1:0] ROB_index_commit;
  logic                       rollback;
  logic [31:0]                redirect_pc;

  modport master (
    output alloc_valid, alloc_rd, alloc_rd_we, alloc_pc,
    output wb_valid, wb_index, wb_data, wb_mispredict, wb_target,
    output query1_index, query2_index,
    input  alloc_ready, alloc_index,
    input  query1_ready, query2_ready, query1_data, query2_data,
    input  ROB_we, ROB_addr_commit, ROB_data_commit, ROB_index_commit,
    input  rollback, redirect_pc
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_rd_we, alloc_pc,
    input  wb_valid, wb_index, wb_data, wb_mispredict, wb_target,
    input  query1_index, query2_index,
    output alloc_ready, alloc_index,
    output query1_ready, query2_ready, query1_data, query2_data,
    output ROB_we, ROB_addr_commit, ROB_data_commit, ROB_index_commit,
    output rollback, redirect_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocate at tail, write back by index, retire at
// head, full flush on a mispredicted branch reaching the head.
module reorder_buffer #(
  parameter int ROB_ENTRY_NUM   = rob_pkg::ROB_ENTRY_NUM,
  parameter int ROB_ENTRY_WIDTH = rob_pkg::ROB_ENTRY_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  reorder_buffer_if.slave rob
);
  import rob_pkg::*;

  localparam int         W       = ROB_ENTRY_WIDTH;
  localparam logic [W:0] PTR_ONE = (W+1)'(1);

  rob_entry_t [ROB_ENTRY_NUM-1:0] ent;
  logic [W:0]   head, tail;
  logic [W-1:0] head_idx, tail_idx;
  rob_entry_t   head_ent;
  logic         full, alloc_fire, commit, flush, wb_hit;
  logic         rollback_q;
  logic [31:0]  redirect_q;
  logic         q1_byp, q2_byp;

  assign head_idx   = head[W-1:0];
  assign tail_idx   = tail[W-1:0];
  assign head_ent   = ent[head_idx];
  // Wrap bits differ with equal index bits: the tail has lapped the head.
  assign full       = (head[W] != tail[W]) && (head_idx == tail_idx);
  assign alloc_fire = rob.alloc_valid && rob.alloc_ready;
  assign commit     = head_ent.valid && head_ent.done && !rollback_q;
  assign flush      = commit && head_ent.mispredict;
  assign wb_hit     = rob.wb_valid && ent[rob.wb_index].valid && !rollback_q;

  assign rob.alloc_ready      = !full && !rollback_q;
  assign rob.alloc_index      = tail_idx;
  assign rob.ROB_we           = commit && head_ent.rd_we && (head_ent.rd != 5'd0);
  assign rob.ROB_addr_commit  = head_ent.rd;
  assign rob.ROB_data_commit  = head_ent.data;
  assign rob.ROB_index_commit = head_idx;
  assign rob.rollback         = rollback_q;
  assign rob.redirect_pc      = redirect_q;

  // Operand lookup with same-cycle forwarding of an in-flight writeback.
  assign q1_byp = rob.wb_valid && (rob.wb_index == rob.query1_index) && ent[rob.query1_index].valid;
  assign q2_byp = rob.wb_valid && (rob.wb_index == rob.query2_index) && ent[rob.query2_index].valid;

  assign rob.query1_ready = (ent[rob.query1_index].valid && ent[rob.query1_index].done) || q1_byp;
  assign rob.query2_ready = (ent[rob.query2_index].valid && ent[rob.query2_index].done) || q2_byp;
  assign rob.query1_data  = q1_byp ? rob.wb_data : ent[rob.query1_index].data;
  assign rob.query2_data  = q2_byp ? rob.wb_data : ent[rob.query2_index].data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent        <= '0;
      head       <= '0;
      tail       <= '0;
      rollback_q <= 1'b0;
      redirect_q <= '0;
    end else if (flush) begin
      // Everything younger than the branch is wrong-path; drop it all.
      ent        <= '0;
      head       <= '0;
      tail       <= '0;
      rollback_q <= 1'b1;
      redirect_q <= head_ent.target;
    end else begin
      rollback_q <= 1'b0;
      if (wb_hit) begin
        ent[rob.wb_index].done       <= 1'b1;
        ent[rob.wb_index].data       <= rob.wb_data;
        ent[rob.wb_index].mispredict <= rob.wb_mispredict;
        ent[rob.wb_index].target     <= rob.wb_target;
      end
      if (commit) begin
        ent[head_idx].valid <= 1'b0;
        head                <= head + PTR_ONE;
      end
      // Allocation never aliases the head here: a full ROB cannot allocate.
      if (alloc_fire) begin
        ent[tail_idx] <= new_entry(rob.alloc_rd, rob.alloc_rd_we, rob.alloc_pc);
        tail          <= tail + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and random checks of reorder_buffer against a queue-based model.
module tb_reorder_buffer;
  localparam int N = 16;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_ENTRY_WIDTH(W)) bus ();

  reorder_buffer #(.ROB_ENTRY_NUM(N), .ROB_ENTRY_WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rob  (bus)
  );

  typedef struct {
    int          idx;
    logic [4:0]  rd;
    bit          rd_we;
    bit          done;
    bit          mis;
    logic [31:0] data;
    logic [31:0] tgt;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_head, m_tail;
  bit          m_rb;
  logic [31:0] m_redir;
  int          nvec, nerr;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find(int i);
    foreach (mq[k]) if (mq[k].idx == i) return k;
    return -1;
  endfunction

  function automatic bit m_commit();
    return (mq.size() > 0) && mq[0].done && !m_rb;
  endfunction

  task automatic qchk(string tag, int qi, logic rdy, logic [31:0] dat);
    int k;
    bit er, byp;
    logic [31:0] ed;
    k  = find(qi);
    er = 1'b0;
    ed = '0;
    if (k >= 0) begin
      byp = bus.wb_valid && (int'(bus.wb_index) == qi);
      er  = mq[k].done || byp;
      ed  = byp ? bus.wb_data : mq[k].data;
    end
    chk({tag, "_ready"}, 32'(rdy), 32'(er));
    if (er) chk({tag, "_data"}, dat, ed);
  endtask

  task automatic model_check();
    bit cm;
    cm = m_commit();
    chk("alloc_ready", 32'(bus.alloc_ready), 32'(mq.size() < N && !m_rb));
    chk("alloc_index", 32'(bus.alloc_index), 32'(m_tail % N));
    chk("ROB_index_commit", 32'(bus.ROB_index_commit), 32'(m_head % N));
    if (cm) begin
      chk("ROB_we", 32'(bus.ROB_we), 32'(mq[0].rd_we && mq[0].rd != 5'd0));
      chk("ROB_addr_commit", 32'(bus.ROB_addr_commit), 32'(mq[0].rd));
      chk("ROB_data_commit", bus.ROB_data_commit, mq[0].data);
    end else begin
      chk("ROB_we_idle", 32'(bus.ROB_we), 32'd0);
    end
    chk("rollback", 32'(bus.rollback), 32'(m_rb));
    if (m_rb) chk("redirect_pc", bus.redirect_pc, m_redir);
    qchk("query1", int'(bus.query1_index), bus.query1_ready, bus.query1_data);
    qchk("query2", int'(bus.query2_index), bus.query2_ready, bus.query2_data);
  endtask

  task automatic model_update();
    bit cm, acc;
    int k;
    m_ent_t e;
    cm  = m_commit();
    acc = bus.alloc_valid && (mq.size() < N) && !m_rb;
    if (m_rb) begin
      m_rb = 1'b0;
    end else if (cm && mq[0].mis) begin
      m_redir = mq[0].tgt;
      mq.delete();
      m_head = 0;
      m_tail = 0;
      m_rb   = 1'b1;
    end else begin
      if (bus.wb_valid) begin
        k = find(int'(bus.wb_index));
        if (k >= 0) begin
          mq[k].done = 1'b1;
          mq[k].data = bus.wb_data;
          mq[k].mis  = bus.wb_mispredict;
          mq[k].tgt  = bus.wb_target;
        end
      end
      if (cm) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % (2 * N);
      end
      if (acc) begin
        e = '{idx: m_tail % N, rd: bus.alloc_rd, rd_we: bus.alloc_rd_we,
              done: 1'b0, mis: 1'b0, data: 32'd0, tgt: 32'd0};
        mq.push_back(e);
        m_tail = (m_tail + 1) % (2 * N);
      end
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked at the falling edge.
  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid   = 1'b0;
    bus.alloc_rd      = '0;
    bus.alloc_rd_we   = 1'b0;
    bus.alloc_pc      = '0;
    bus.wb_valid      = 1'b0;
    bus.wb_index      = '0;
    bus.wb_data       = '0;
    bus.wb_mispredict = 1'b0;
    bus.wb_target     = '0;
    bus.query1_index  = '0;
    bus.query2_index  = '0;
  endtask

  task automatic drv_alloc(logic [4:0] rd, logic we);
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = rd;
    bus.alloc_rd_we = we;
    bus.alloc_pc    = $urandom;
  endtask

  task automatic drv_wb(int idx, logic [31:0] data, logic mis, logic [31:0] tgt);
    bus.wb_valid      = 1'b1;
    bus.wb_index      = W'(idx);
    bus.wb_data       = data;
    bus.wb_mispredict = mis;
    bus.wb_target     = tgt;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    mq.delete();
    m_head  = 0;
    m_tail  = 0;
    m_rb    = 1'b0;
    m_redir = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;

    // Reset state
    do_reset();
    settle();
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst_alloc_index", 32'(bus.alloc_index), 32'd0);
    chk("rst_ROB_we", 32'(bus.ROB_we), 32'd0);
    chk("rst_addr_commit", 32'(bus.ROB_addr_commit), 32'd0);
    chk("rst_data_commit", bus.ROB_data_commit, 32'd0);
    chk("rst_rollback", 32'(bus.rollback), 32'd0);
    chk("rst_redirect", bus.redirect_pc, 32'd0);
    chk("rst_q1_ready", 32'(bus.query1_ready), 32'd0);
    adv();

    // Basic allocate -> writeback -> commit
    drv_alloc(5'd5, 1'b1);
    settle(); adv();
    idle(); drv_wb(0, 32'h1234, 1'b0, 32'h0);
    settle(); adv();
    idle();
    settle();
    chk("t1_ROB_we", 32'(bus.ROB_we), 32'd1);
    chk("t1_addr", 32'(bus.ROB_addr_commit), 32'd5);
    chk("t1_data", bus.ROB_data_commit, 32'h1234);
    chk("t1_index", 32'(bus.ROB_index_commit), 32'd0);
    adv();

    // Fill to capacity, then free one slot
    do_reset();
    for (int i = 0; i < N; i++) begin
      drv_alloc(5'($urandom_range(1, 31)), 1'b1);
      settle(); adv();
    end
    drv_wb(0, 32'hA5A5, 1'b0, 32'h0);
    settle();
    chk("t2_full_ready", 32'(bus.alloc_ready), 32'd0);
    adv();
    idle();
    settle();
    chk("t2_commit_we", 32'(bus.ROB_we), 32'd1);
    adv();
    drv_alloc(5'd9, 1'b1);
    settle();
    chk("t2_ready_after", 32'(bus.alloc_ready), 32'd1);
    chk("t2_wrap_index", 32'(bus.alloc_index), 32'd0);
    adv();

    // Out-of-order writeback, in-order commit
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv_alloc(5'(i + 1), 1'b1);
      settle(); adv();
    end
    for (int i = 2; i >= 0; i--) begin
      idle(); drv_wb(i, 32'h100 + 32'(i), 1'b0, 32'h0);
      settle(); adv();
    end
    idle();
    for (int j = 0; j < 3; j++) begin
      settle();
      chk("t3_we", 32'(bus.ROB_we), 32'd1);
      chk("t3_index", 32'(bus.ROB_index_commit), 32'(j));
      chk("t3_data", bus.ROB_data_commit, 32'h100 + 32'(j));
      adv();
    end

    // Mispredicted branch at index 1
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv_alloc(5'(i + 1), 1'b1);
      settle(); adv();
    end
    idle(); drv_wb(1, 32'h0, 1'b1, 32'h80);
    settle(); adv();
    idle(); drv_wb(0, 32'h77, 1'b0, 32'h0);
    settle(); adv();
    idle();
    settle(); adv();
    settle();
    chk("t4_commit_idx", 32'(bus.ROB_index_commit), 32'd1);
    chk("t4_no_rb_yet", 32'(bus.rollback), 32'd0);
    adv();
    drv_alloc(5'd4, 1'b1);
    settle();
    chk("t4_rollback", 32'(bus.rollback), 32'd1);
    chk("t4_redirect", bus.redirect_pc, 32'h80);
    chk("t4_no_alloc", 32'(bus.alloc_ready), 32'd0);
    adv();
    settle();
    chk("t4_rb_done", 32'(bus.rollback), 32'd0);
    chk("t4_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("t4_alloc_index", 32'(bus.alloc_index), 32'd0);
    adv();

    // Query bypass and commit of rd=0
    do_reset();
    drv_alloc(5'd0, 1'b1);
    settle(); adv();
    for (int i = 1; i < 4; i++) begin
      drv_alloc(5'd7, 1'b1);
      settle(); adv();
    end
    idle(); drv_wb(3, 32'hBEEF, 1'b0, 32'h0);
    bus.query1_index = 4'd3;
    settle();
    chk("t5_byp_ready", 32'(bus.query1_ready), 32'd1);
    chk("t5_byp_data", bus.query1_data, 32'hBEEF);
    adv();
    drv_wb(0, 32'h55, 1'b0, 32'h0);
    settle();
    chk("t5_stored_data", bus.query1_data, 32'hBEEF);
    adv();
    idle();
    settle();
    chk("t5_rd0_index", 32'(bus.ROB_index_commit), 32'd0);
    chk("t5_rd0_we", 32'(bus.ROB_we), 32'd0);
    adv();

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 2) != 0)
        drv_alloc(5'($urandom), 1'($urandom));
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
        drv_wb(mq[$urandom_range(0, mq.size() - 1)].idx, $urandom,
               1'($urandom_range(0, 23) == 0), $urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        drv_wb($urandom_range(0, N - 1), $urandom, 1'($urandom), $urandom);
      end
      bus.query1_index = (mq.size() > 0 && $urandom_range(0, 1) == 1)
                         ? W'(mq[$urandom_range(0, mq.size() - 1)].idx) : W'($urandom);
      bus.query2_index = bus.wb_valid ? bus.wb_index : W'($urandom);
      settle(); adv();
    end

    // Reset in the middle of traffic drops everything at once
    drv_alloc(5'd3, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("mid_alloc_index", 32'(bus.alloc_index), 32'd0);
    chk("mid_ROB_we", 32'(bus.ROB_we), 32'd0);
    chk("mid_rollback", 32'(bus.rollback), 32'd0);
    chk("mid_q2_ready", 32'(bus.query2_ready), 32'd0);
    do_reset();
    settle();
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
